// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline run controller and the hazard unit:
// run-state encoding and the default pipeline depth.
package pipe_pkg;

  localparam int PIPE_DEPTH_DEF = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } run_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of
// wrapping so long runs never report a misleadingly small count.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run controller for a classic 5-stage pipeline: start/init, hazard strobes,
// halt or watchdog drain, and cycle/retire statistics.
//
// state   | meaning
// IDLE    | waiting for startin, all enables off
// INIT    | one cycle: reset PC, bubble IF/ID and ID/EX, clear statistics
// RUN     | pipeline advancing; stall/branch/halt strobes active
// DRAIN   | fetch stopped, back half retires in-flight work for PIPE_DEPTH-1 cycles
// DONE    | one-cycle done pulse, statistics held
module pipe_run_ctrl
  import pipe_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startin,
  input  logic             stall_req,
  input  logic             branch_taken,
  input  logic             halt_detect,
  input  logic             wb_valid,
  input  logic [CNT_W-1:0] max_cycles,
  output logic             pc_reset,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             run_en,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam int DRAIN_W = $clog2(PIPE_DEPTH);
  // Down-counter loaded with PIPE_DEPTH-2 so terminal count 0 marks the last drain cycle.
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(PIPE_DEPTH - 2);

  run_state_e         state, state_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic               timeout_nxt;
  logic               active;
  logic               wd_hit;

  assign active = (state == S_RUN) || (state == S_DRAIN);
  assign wd_hit = (max_cycles != '0) && (cycle_cnt == max_cycles - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      drain_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    drain_nxt   = drain_cnt;
    timeout_nxt = timeout;
    pc_reset    = 1'b0;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    run_en      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (startin) state_nxt = S_INIT;
      end
      S_INIT: begin
        busy        = 1'b1;
        pc_reset    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        timeout_nxt = 1'b0;
        state_nxt   = S_RUN;
      end
      S_RUN: begin
        busy    = 1'b1;
        run_en  = 1'b1;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        // Branch wins over stall and halt: the wrong-path work is squashed anyway.
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (stall_req) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_flush = 1'b1;
        end else if (halt_detect) begin
          pc_we      = 1'b0;
          ifid_flush = 1'b1;
        end
        if (wd_hit) begin
          timeout_nxt = 1'b1;
          drain_nxt   = DRAIN_LOAD;
          state_nxt   = S_DRAIN;
        end else if (halt_detect && !branch_taken && !stall_req) begin
          drain_nxt = DRAIN_LOAD;
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy       = 1'b1;
        run_en     = 1'b1;
        idex_flush = 1'b1;
        if (drain_cnt == '0) begin
          state_nxt = S_DONE;
        end else begin
          drain_nxt = drain_cnt - DRAIN_W'(1);
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == S_INIT),
    .inc   (active),
    .count (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == S_INIT),
    .inc   (active && wb_valid),
    .count (retire_cnt)
  );

endmodule
